spill_tracker: RTL and testbench

Parametrised successor to the single-counter spill counter: tracks the beam LIVE gate, numbers spills, counts triggers and LIVE clock cycles per spill, and emits a per-spill summary record through a valid/ready handshake. Sits between the LIVE/trigger distribution logic and the readout/header builder of the OFC1 firmware. Adds loadable spill number, partial-spill rejection after reset, and record-overflow detection.

---
 rtl/spill_tracker.sv | 119 +++++++++++
 tb/tb_spill_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spill_tracker.sv
// Beam spill tracker: follows the LIVE gate, numbers spills, counts triggers and
// LIVE cycles per spill, and hands out one summary record per spill over valid/ready.
// Optional build macro SPILL_TRACKER_LIVE_SYNC_EN adds a 2-flop synchroniser on live.
module spill_tracker #(
    parameter int SPILL_W = 16,
    parameter int EVT_W   = 24,
    parameter int CYC_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               live,
    input  logic               trig,
    input  logic               spill_load,
    input  logic [SPILL_W-1:0] spill_load_val,
    input  logic               rec_ready,
    input  logic               ovf_clr,
    output logic [SPILL_W-1:0] spillno,
    output logic               in_spill,
    output logic               rec_valid,
    output logic [SPILL_W-1:0] rec_spillno,
    output logic [EVT_W-1:0]   rec_events,
    output logic [CYC_W-1:0]   rec_cycles,
    output logic               rec_ovf
);

    typedef enum logic [1:0] {ARM, IDLE, LIVE} state_t;

    state_t             state, state_nxt;
    logic               live_i;
    logic               rise, fall;
    logic               hold, xfer;
    logic [EVT_W-1:0]   evt_cnt;
    logic [CYC_W-1:0]   cyc_cnt;

`ifdef SPILL_TRACKER_LIVE_SYNC_EN
    logic [1:0] live_sync;

    always_ff @(posedge clk) begin
        if (reset) live_sync <= '0;
        else       live_sync <= {live_sync[0], live};
    end

    assign live_i = live_sync[1];
`else
    assign live_i = live;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ARM;
        else       state <= state_nxt;
    end

    // ARM swallows whatever spill is already open when reset releases.
    always_comb begin
        state_nxt = state;
        rise      = 1'b0;
        fall      = 1'b0;
        case (state)
            ARM:  if (!live_i) state_nxt = IDLE;
            IDLE: if (live_i) begin
                      state_nxt = LIVE;
                      rise      = 1'b1;
                  end
            LIVE: if (!live_i) begin
                      state_nxt = IDLE;
                      fall      = 1'b1;
                  end
            default: state_nxt = ARM;
        endcase
    end

    assign in_spill = (state == LIVE);

    always_ff @(posedge clk) begin
        if (reset)           spillno <= '0;
        else if (spill_load) spillno <= spill_load_val;
        else if (rise)       spillno <= spillno + SPILL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt <= '0;
            cyc_cnt <= '0;
        end else if (rise) begin
            evt_cnt <= {{(EVT_W-1){1'b0}}, trig};
            cyc_cnt <= CYC_W'(1);
        end else if (state == LIVE && live_i) begin
            if (trig && evt_cnt != '1) evt_cnt <= evt_cnt + EVT_W'(1);
            if (cyc_cnt != '1)         cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

    // A held (unconsumed) record wins over a new one; a same-edge transfer frees the slot.
    assign hold = rec_valid && !rec_ready;
    assign xfer = rec_valid && rec_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_valid   <= 1'b0;
            rec_spillno <= '0;
            rec_events  <= '0;
            rec_cycles  <= '0;
        end else if (fall && !hold) begin
            rec_valid   <= 1'b1;
            rec_spillno <= spillno;
            rec_events  <= evt_cnt;
            rec_cycles  <= cyc_cnt;
        end else if (xfer) begin
            rec_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)              rec_ovf <= 1'b0;
        else if (fall && hold)  rec_ovf <= 1'b1;
        else if (ovf_clr)       rec_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_spill_tracker.sv
// Directed bench for spill_tracker: inputs change on the falling edge, outputs are
// checked on the falling edge after the rising edge that produced them.
module tb_spill_tracker;

    localparam int SPILL_W = 16;
    localparam int EVT_W   = 4;
    localparam int CYC_W   = 32;
`ifdef SPILL_TRACKER_LIVE_SYNC_EN
    localparam int LAT  = 2;
    localparam int SKIP = 1;  // synchroniser resets to 0, so a spill held through reset is seen
`else
    localparam int LAT  = 0;
    localparam int SKIP = 0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               live = 1'b0;
    logic               trig = 1'b0;
    logic               spill_load = 1'b0;
    logic [SPILL_W-1:0] spill_load_val = '0;
    logic               rec_ready = 1'b0;
    logic               ovf_clr = 1'b0;
    logic [SPILL_W-1:0] spillno;
    logic               in_spill;
    logic               rec_valid;
    logic [SPILL_W-1:0] rec_spillno;
    logic [EVT_W-1:0]   rec_events;
    logic [CYC_W-1:0]   rec_cycles;
    logic               rec_ovf;

    int nvec = 0;
    int nerr = 0;

    spill_tracker #(.SPILL_W(SPILL_W), .EVT_W(EVT_W), .CYC_W(CYC_W)) dut (
        .clk(clk), .reset(reset), .live(live), .trig(trig),
        .spill_load(spill_load), .spill_load_val(spill_load_val),
        .rec_ready(rec_ready), .ovf_clr(ovf_clr),
        .spillno(spillno), .in_spill(in_spill), .rec_valid(rec_valid),
        .rec_spillno(rec_spillno), .rec_events(rec_events),
        .rec_cycles(rec_cycles), .rec_ovf(rec_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One spill of len LIVE edges as seen internally; mask bit i = trig on LIVE edge i.
    task automatic spill(input int len, input logic [31:0] mask, input bit load_rise,
                         input bit rdy_fall);
        for (int j = 0; j <= len + LAT; j++) begin
            @(negedge clk);
            if (j == LAT + 2) check("in_spill_mid", 64'(in_spill), 64'd1);
            live       = (j < len);
            trig       = (j >= LAT && j - LAT < len) ? mask[j - LAT] : 1'b0;
            spill_load = load_rise && (j == LAT);
            if (rdy_fall && j == len + LAT) rec_ready = 1'b1;
        end
        @(negedge clk);
        if (rdy_fall) rec_ready = 1'b0;
    endtask

    task automatic consume();
        rec_ready = 1'b1;
        tick(1);
        rec_ready = 1'b0;
    endtask

    initial begin
        // reset state
        tick(2);
        check("rst_spillno", 64'(spillno), 64'd0);
        check("rst_in_spill", 64'(in_spill), 64'd0);
        check("rst_rec_valid", 64'(rec_valid), 64'd0);
        check("rst_rec_ovf", 64'(rec_ovf), 64'd0);
        check("rst_rec_cycles", 64'(rec_cycles), 64'd0);

        // basic spill: 10 LIVE edges, trig on 3 of them
        reset = 1'b0;
        tick(2);
        spill(10, 32'h92, 1'b0, 1'b0);
        check("t1_spillno", 64'(spillno), 64'd1);
        check("t1_in_spill", 64'(in_spill), 64'd0);
        check("t1_rec_valid", 64'(rec_valid), 64'd1);
        check("t1_rec_spillno", 64'(rec_spillno), 64'd1);
        check("t1_rec_events", 64'(rec_events), 64'd3);
        check("t1_rec_cycles", 64'(rec_cycles), 64'd10);

        // live held through reset release: that partial spill is not counted
        reset = 1'b1;
        live  = 1'b1;
        tick(2);
        check("t2_rst_rec_valid", 64'(rec_valid), 64'd0);
        reset = 1'b0;
        tick(5);
        check("t2_arm_in_spill", 64'(in_spill), 64'(LAT != 0));
        check("t2_arm_spillno", 64'(spillno), 64'(SKIP));
        live = 1'b0;
        tick(4);
        consume();
        spill(4, 32'h1, 1'b0, 1'b0);
        check("t2_rec_valid", 64'(rec_valid), 64'd1);
        check("t2_rec_spillno", 64'(rec_spillno), 64'(1 + SKIP));
        check("t2_rec_events", 64'(rec_events), 64'd1);
        check("t2_rec_cycles", 64'(rec_cycles), 64'd4);
        consume();
        check("t2_consumed", 64'(rec_valid), 64'd0);

        // two spills with no consumer: first record held, overflow flagged
        spill(3, 32'h0, 1'b0, 1'b0);
        check("t3_a_rec_spillno", 64'(rec_spillno), 64'(2 + SKIP));
        spill(5, 32'h7, 1'b0, 1'b0);
        check("t3_ovf", 64'(rec_ovf), 64'd1);
        check("t3_held_valid", 64'(rec_valid), 64'd1);
        check("t3_held_spillno", 64'(rec_spillno), 64'(2 + SKIP));
        check("t3_held_events", 64'(rec_events), 64'd0);
        check("t3_held_cycles", 64'(rec_cycles), 64'd3);
        check("t3_spillno", 64'(spillno), 64'(3 + SKIP));
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 64'(rec_ovf), 64'd0);
        // fall coinciding with a transfer: new record loads, no overflow
        spill(2, 32'h0, 1'b0, 1'b1);
        check("t3_swap_valid", 64'(rec_valid), 64'd1);
        check("t3_swap_spillno", 64'(rec_spillno), 64'(4 + SKIP));
        check("t3_swap_cycles", 64'(rec_cycles), 64'd2);
        check("t3_swap_ovf", 64'(rec_ovf), 64'd0);
        consume();

        // spill number wrap
        spill_load_val = 16'hFFFF;
        spill_load     = 1'b1;
        tick(1);
        spill_load     = 1'b0;
        check("t4_load", 64'(spillno), 64'hFFFF);
        spill(3, 32'h0, 1'b0, 1'b0);
        check("t4_wrap_spillno", 64'(spillno), 64'd0);
        check("t4_wrap_rec_spillno", 64'(rec_spillno), 64'd0);
        consume();

        // event saturation at EVT_W=4, spill_load on the rise edge wins over increment
        spill_load_val = 16'h1234;
        spill(20, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("t5_spillno", 64'(spillno), 64'h1234);
        check("t5_rec_spillno", 64'(rec_spillno), 64'h1234);
        check("t5_rec_events", 64'(rec_events), 64'hF);
        check("t5_rec_cycles", 64'(rec_cycles), 64'd20);

        // reset mid-spill (record from t5 still held) clears everything
        live = 1'b1;
        tick(LAT + 4);
        check("t6_in_spill", 64'(in_spill), 64'd1);
        reset = 1'b1;
        tick(1);
        check("t6_spillno", 64'(spillno), 64'd0);
        check("t6_in_spill_rst", 64'(in_spill), 64'd0);
        check("t6_rec_valid", 64'(rec_valid), 64'd0);
        check("t6_rec_spillno", 64'(rec_spillno), 64'd0);
        check("t6_rec_events", 64'(rec_events), 64'd0);
        reset = 1'b0;
        live  = 1'b0;
        tick(4);
        check("t6_no_record", 64'(rec_valid), 64'd0);
        check("t6_spillno_after", 64'(spillno), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
